float_convert_pipe: RTL and testbench

Pipelined, parametrised IEEE-style float-to-float format converter. It takes one sign/exponent/fraction word per cycle in any (EXP_IN, FRAC_IN) format and emits the (EXP_OUT, FRAC_OUT) equivalent, rounded to nearest-even, with exception flags. It sits between datapath units using different float widths, for example an fp32 accumulator feeding an fp16 store path. It uses valid/ready handshakes on both sides.

---
 rtl/float_convert_pipe.sv | 193 +++++++++++++++++++
 tb/tb_float_convert_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/float_convert_pipe.sv
// float_convert_pipe: two-stage float-to-float converter (unpack/normalize, then round-nearest-even/pack).
// Define FLOAT_CONVERT_DENORMAL_EN for denormal support; otherwise denormals flush to signed zero.
module float_convert_pipe #(
  parameter int EXP_IN   = 8,
  parameter int FRAC_IN  = 23,
  parameter int EXP_OUT  = 5,
  parameter int FRAC_OUT = 10
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [EXP_IN+FRAC_IN:0]     inData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [EXP_OUT+FRAC_OUT:0]   outData,
  output logic [3:0]                  outFlags
);
  localparam int EW       = ((EXP_IN > EXP_OUT) ? EXP_IN : EXP_OUT) + 2;
  localparam int BIAS_IN  = (1 << (EXP_IN - 1)) - 1;
  localparam int BIAS_OUT = (1 << (EXP_OUT - 1)) - 1;
  localparam int MW       = FRAC_IN + FRAC_OUT + 4;
  localparam logic signed [EW-1:0] BIAS_IN_S  = EW'(BIAS_IN);
  localparam logic signed [EW-1:0] BIAS_OUT_S = EW'(BIAS_OUT);
  localparam logic signed [EW-1:0] TINY_LIM   = EW'(1 - BIAS_OUT);
  localparam logic signed [EW-1:0] EXP_MAX_S  = EW'((1 << EXP_OUT) - 1);
`ifdef FLOAT_CONVERT_DENORMAL_EN
  localparam int CW = $clog2(FRAC_IN + 1);
  localparam int SW = $clog2(FRAC_OUT + 3);
  localparam logic signed [EW-1:0] SH_MAX_S = EW'(FRAC_OUT + 2);

  function automatic logic [CW-1:0] lead_zeros(input logic [FRAC_IN-1:0] f);
    lead_zeros = CW'(FRAC_IN);
    for (int i = 0; i < FRAC_IN; i++) begin
      if (f[i]) lead_zeros = CW'(FRAC_IN - 1 - i);
    end
  endfunction
`endif

  logic s1_valid_reg, s2_valid_reg, s1_adv, s2_adv;
  logic s1_sign_reg, s1_nan_reg, s1_inf_reg, s1_zero_reg, s1_dz_reg;
  logic s1_sign_next, s1_nan_next, s1_inf_next, s1_zero_next, s1_dz_next;
  logic signed [EW-1:0] s1_exp_reg, s1_exp_next;
  logic [FRAC_IN:0] s1_mant_reg, s1_mant_next;
  logic [EXP_OUT+FRAC_OUT:0] out_data_reg, out_data_next;
  logic [3:0] out_flags_reg, out_flags_next;

  assign s2_adv   = !s2_valid_reg || outReady;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign inReady  = s1_adv;
  assign outValid = s2_valid_reg;
  assign outData  = out_data_reg;
  assign outFlags = out_flags_reg;

  // Stage 1: classify, rebias and attach the hidden bit.
  logic [EXP_IN-1:0]    exp_in;
  logic [FRAC_IN-1:0]   frac_in;
  logic                 exp_ones, exp_zero, frac_zero;
  logic signed [EW-1:0] exp_ext;
`ifdef FLOAT_CONVERT_DENORMAL_EN
  logic [CW-1:0]        clz;
  logic signed [EW-1:0] clz_ext;
`endif

  always_comb begin
    exp_in       = inData[FRAC_IN +: EXP_IN];
    frac_in      = inData[FRAC_IN-1:0];
    exp_ones     = &exp_in;
    exp_zero     = ~|exp_in;
    frac_zero    = ~|frac_in;
    s1_sign_next = inData[EXP_IN+FRAC_IN];
    s1_nan_next  = exp_ones && !frac_zero;
    s1_inf_next  = exp_ones && frac_zero;
    s1_zero_next = exp_zero && frac_zero;
    s1_dz_next   = 1'b0;
    exp_ext      = EW'(exp_in);
    s1_exp_next  = exp_ext - BIAS_IN_S;
    s1_mant_next = {1'b1, frac_in};
`ifdef FLOAT_CONVERT_DENORMAL_EN
    clz     = '0;
    clz_ext = '0;
    if (exp_zero && !frac_zero) begin
      // Exponent is 1-bias-(clz+1), which simplifies to -(bias+clz).
      clz          = lead_zeros(frac_in);
      clz_ext      = EW'(clz);
      s1_exp_next  = -(BIAS_IN_S + clz_ext);
      s1_mant_next = {1'b0, frac_in} << (clz + 1'b1);
    end
`else
    s1_dz_next = exp_zero && !frac_zero;
`endif
  end

  // Stage 2: the low pad is wider than the largest denormal shift, so no set bit is lost.
  logic [MW-1:0]        ext, shifted;
  logic [FRAC_OUT:0]    q0;
  logic [FRAC_OUT+1:0]  q;
  logic                 g, r, st, up, inx, tiny, ovf;
  logic signed [EW-1:0] e_r, biased;
`ifdef FLOAT_CONVERT_DENORMAL_EN
  logic signed [EW-1:0] diff;
  logic [SW-1:0]        sh;
`endif

  always_comb begin
    ext  = {s1_mant_reg, {(FRAC_OUT+3){1'b0}}};
    tiny = s1_exp_reg < TINY_LIM;
`ifdef FLOAT_CONVERT_DENORMAL_EN
    diff = TINY_LIM - s1_exp_reg;
    sh   = '0;
    if (tiny) sh = (diff > SH_MAX_S) ? SW'(FRAC_OUT + 2) : diff[SW-1:0];
    shifted = ext >> sh;
`else
    shifted = ext;
`endif
    q0     = shifted[MW-1 -: FRAC_OUT+1];
    g      = shifted[FRAC_IN+2];
    r      = shifted[FRAC_IN+1];
    st     = |shifted[FRAC_IN:0];
    up     = g && (r || st || q0[0]);
    inx    = g || r || st;
    q      = {1'b0, q0} + (FRAC_OUT+2)'(up);
    e_r    = s1_exp_reg + EW'(q[FRAC_OUT+1]);
    biased = e_r + BIAS_OUT_S;
    ovf    = biased >= EXP_MAX_S;

    out_data_next  = '0;
    out_flags_next = '0;
    if (s1_nan_reg) begin
      out_data_next  = {1'b0, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b1}}};
      out_flags_next = 4'b1000;
    end else if (s1_inf_reg) begin
      out_data_next = {s1_sign_reg, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}};
    end else if (s1_zero_reg) begin
      out_data_next = {s1_sign_reg, {(EXP_OUT+FRAC_OUT){1'b0}}};
    end else if (s1_dz_reg) begin
      out_data_next  = {s1_sign_reg, {(EXP_OUT+FRAC_OUT){1'b0}}};
      out_flags_next = 4'b0001;
    end else if (tiny) begin
`ifdef FLOAT_CONVERT_DENORMAL_EN
      // A round-up into bit FRAC_OUT lands in the exponent field as the minimum normal.
      out_data_next  = {s1_sign_reg, {(EXP_OUT-1){1'b0}}, q[FRAC_OUT:0]};
      out_flags_next = {2'b00, inx, inx};
`else
      out_data_next  = {s1_sign_reg, {(EXP_OUT+FRAC_OUT){1'b0}}};
      out_flags_next = 4'b0011;
`endif
    end else if (ovf) begin
      out_data_next  = {s1_sign_reg, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}};
      out_flags_next = 4'b0101;
    end else begin
      out_data_next  = {s1_sign_reg, biased[EXP_OUT-1:0],
                        q[FRAC_OUT+1] ? q[FRAC_OUT:1] : q[FRAC_OUT-1:0]};
      out_flags_next = {3'b000, inx};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_nan_reg    <= 1'b0;
      s1_inf_reg    <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_dz_reg     <= 1'b0;
      s1_exp_reg    <= '0;
      s1_mant_reg   <= '0;
      out_data_reg  <= '0;
      out_flags_reg <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= inValid;
        if (inValid) begin
          s1_sign_reg <= s1_sign_next;
          s1_nan_reg  <= s1_nan_next;
          s1_inf_reg  <= s1_inf_next;
          s1_zero_reg <= s1_zero_next;
          s1_dz_reg   <= s1_dz_next;
          s1_exp_reg  <= s1_exp_next;
          s1_mant_reg <= s1_mant_next;
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_data_reg  <= out_data_next;
          out_flags_reg <= out_flags_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_float_convert_pipe.sv
// Directed bench for float_convert_pipe at default fp32->fp16; tiny-result vectors follow FLOAT_CONVERT_DENORMAL_EN.
module tb_float_convert_pipe;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inData = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] outData;
  logic [3:0]  outFlags;

  int checks = 0;
  int errors = 0;

  float_convert_pipe dut (
    .clock(clock), .resetn(resetn),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outFlags(outFlags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

`ifdef FLOAT_CONVERT_DENORMAL_EN
  localparam logic [15:0] T1_D = 16'h0001; localparam logic [3:0] T1_F = 4'b0000;
  localparam logic [15:0] T2_D = 16'h0400; localparam logic [3:0] T2_F = 4'b0011;
  localparam logic [15:0] T3_D = 16'h0000; localparam logic [3:0] T3_F = 4'b0011;
`else
  localparam logic [15:0] T1_D = 16'h0000; localparam logic [3:0] T1_F = 4'b0011;
  localparam logic [15:0] T2_D = 16'h0000; localparam logic [3:0] T2_F = 4'b0011;
  localparam logic [15:0] T3_D = 16'h0000; localparam logic [3:0] T3_F = 4'b0001;
`endif

  localparam int NV = 12;
  logic [31:0] v_in [NV] = '{32'h3F800000, 32'h477FE000, 32'h477FF000, 32'hFF800000,
                             32'h3F801000, 32'h3F803000, 32'h3FFFF000, 32'h33800000,
                             32'hFFC00001, 32'h80000000, 32'h387FE000, 32'h00000001};
  logic [15:0] v_out [NV] = '{16'h3C00, 16'h7BFF, 16'h7C00, 16'hFC00,
                              16'h3C00, 16'h3C02, 16'h4000, T1_D,
                              16'h7FFF, 16'h8000, T2_D, T3_D};
  logic [3:0] v_flg [NV] = '{4'b0000, 4'b0000, 4'b0101, 4'b0000,
                             4'b0001, 4'b0001, 4'b0001, T1_F,
                             4'b1000, 4'b0000, T2_F, T3_F};

  logic [31:0] bp_in  [6] = '{32'h3F800000, 32'h40000000, 32'h3F000000,
                              32'hBF800000, 32'h477FE000, 32'h3F803000};
  logic [15:0] bp_exp [6] = '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00, 16'h7BFF, 16'h3C02};

  task automatic send_vec(input int k);
    string tag;
    tag = $sformatf("v%0d_%h", k, v_in[k]);
    check({tag, "_rdy"}, 32'(inReady), 32'd1);
    inValid = 1'b1;
    inData  = v_in[k];
    @(posedge clock); #1;
    inValid = 1'b0;
    check({tag, "_lat1"}, 32'(outValid), 32'd0);
    @(posedge clock); #1;
    check({tag, "_lat2"}, 32'(outValid), 32'd1);
    check({tag, "_data"}, 32'(outData), 32'(v_out[k]));
    check({tag, "_flags"}, 32'(outFlags), 32'(v_flg[k]));
  endtask

  initial begin
    int idx, ocnt, first_emit, last_emit, stale;
    logic acc, emit;
    logic [15:0] held;

    #1;
    check("rst_outvalid", 32'(outValid), 32'd0);
    check("rst_outdata", 32'(outData), 32'd0);
    check("rst_outflags", 32'(outFlags), 32'd0);
    check("rst_inready", 32'(inReady), 32'd1);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int k = 0; k < NV; k++) send_vec(k);
    @(posedge clock); #1;

    // Backpressure: consumer stalls for the first five cycles.
    idx = 0; ocnt = 0; first_emit = -1; last_emit = -1; held = '0;
    for (int c = 0; c < 30; c++) begin
      outReady = (c >= 5);
      inValid  = (idx < 6);
      if (idx < 6) inData = bp_in[idx];
      @(negedge clock);
      if (c < 5) check($sformatf("bp_ready_c%0d", c), 32'(inReady), (c < 2) ? 32'd1 : 32'd0);
      if (c == 2) held = outData;
      if (c == 4) begin
        check("bp_stall_valid", 32'(outValid), 32'd1);
        check("bp_stall_hold", 32'(outData), 32'(held));
      end
      acc  = inValid && inReady;
      emit = outValid && outReady;
      if (emit) begin
        if (ocnt < 6) check($sformatf("bp_out%0d", ocnt), 32'(outData), 32'(bp_exp[ocnt]));
        else check("bp_extra_output", 32'(ocnt), 32'd5);
        if (first_emit < 0) first_emit = c;
        last_emit = c;
        ocnt++;
      end
      @(posedge clock); #1;
      if (acc) idx++;
    end
    inValid = 1'b0;
    check("bp_accepted", 32'(idx), 32'd6);
    check("bp_emitted", 32'(ocnt), 32'd6);
    check("bp_burst_span", 32'(last_emit - first_emit), 32'd5);

    // Reset with two words held in flight.
    outReady = 1'b0;
    inValid  = 1'b1;
    inData   = 32'h3F800000;
    @(posedge clock); #1;
    inData   = 32'h40000000;
    @(posedge clock); #1;
    inValid  = 1'b0;
    check("rst2_pre_valid", 32'(outValid), 32'd1);
    check("rst2_pre_ready", 32'(inReady), 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("rst2_async_valid", 32'(outValid), 32'd0);
    check("rst2_async_data", 32'(outData), 32'd0);
    check("rst2_async_ready", 32'(inReady), 32'd1);
    repeat (2) @(negedge clock);
    resetn   = 1'b1;
    outReady = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (outValid) stale++;
    end
    check("rst2_no_stale", 32'(stale), 32'd0);
    check("rst2_ready", 32'(inReady), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
